// File: rtl/slide_pot_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// slide_pot_sequencer: round-robin A2D scheduler for the six slide pots; holds
// the latest 12-bit result per pot. Optional macro POT_SMOOTH_EN adds smoothing.
// Revision 1.0
//------------------------------------------------------------------------------
module slide_pot_sequencer #(
   parameter int SWEEP_GAP = 4096,
   parameter int TIMEOUT   = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        restart_i,
   output logic        strt_cnv_o,
   output logic [2:0]  chnl_o,
   input  logic        cnv_cmplt_i,
   input  logic [11:0] res_i,
   output logic [11:0] lp_gain_o,
   output logic [11:0] b1_gain_o,
   output logic [11:0] b2_gain_o,
   output logic [11:0] b3_gain_o,
   output logic [11:0] hp_gain_o,
   output logic [11:0] volume_o,
   output logic        sweep_done_o,
   output logic        all_valid_o,
   output logic        timeout_err_o
);

   localparam int              GW         = $clog2(SWEEP_GAP + 1);
   localparam int              TW         = $clog2(TIMEOUT + 1);
   localparam logic [GW-1:0]   GAP_RELOAD = GW'(SWEEP_GAP - 1);
   localparam logic [TW-1:0]   TMO_LOAD   = TW'(TIMEOUT - 1);
   localparam logic [2:0]      LAST_SLOT  = 3'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      STORE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    slot_q, slot_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [2:0]    chnl_q, chnl_d;
   logic [11:0]   res_q, res_d;
   logic          ok_q, ok_d;
   logic [5:0]    valid_q, valid_d;
   logic          terr_q, terr_d;
   logic [11:0]   pot_q [6];
   logic [11:0]   pot_d [6];
   logic [11:0]   store_val;

   function automatic logic [2:0] chnl_of(input logic [2:0] slot);
      case (slot)
         3'd0:    chnl_of = 3'd1;
         3'd1:    chnl_of = 3'd0;
         3'd2:    chnl_of = 3'd4;
         3'd3:    chnl_of = 3'd2;
         3'd4:    chnl_of = 3'd3;
         default: chnl_of = 3'd7;
      endcase
   endfunction

`ifdef POT_SMOOTH_EN
   logic signed [12:0] delta, blend;
   // Quarter-step IIR toward the new sample; a slot's first sample is taken as-is.
   always_comb begin
      delta     = $signed({1'b0, res_q}) - $signed({1'b0, pot_q[slot_q]});
      blend     = $signed({1'b0, pot_q[slot_q]}) + (delta >>> 2);
      store_val = valid_q[slot_q] ? blend[11:0] : res_q;
   end
`else
   assign store_val = res_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         slot_q  <= '0;
         gap_q   <= GW'(1);
         tmo_q   <= '0;
         chnl_q  <= '0;
         res_q   <= '0;
         ok_q    <= 1'b0;
         valid_q <= '0;
         terr_q  <= 1'b0;
         pot_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         gap_q   <= gap_d;
         tmo_q   <= tmo_d;
         chnl_q  <= chnl_d;
         res_q   <= res_d;
         ok_q    <= ok_d;
         valid_q <= valid_d;
         terr_q  <= terr_d;
         pot_q   <= pot_d;
      end
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      gap_d   = gap_q;
      tmo_d   = tmo_q;
      chnl_d  = chnl_q;
      res_d   = res_q;
      ok_d    = ok_q;
      valid_d = valid_q;
      terr_d  = terr_q;
      pot_d   = pot_q;
      if (restart_i) begin
         state_d = START;
         slot_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gap_q == '0) state_d = START;
               else             gap_d   = gap_q - GW'(1);
            end
            START: begin
               tmo_d   = TMO_LOAD;
               state_d = WAIT;
            end
            WAIT: begin
               // A completion in the expiry cycle still wins over the timeout.
               if (cnv_cmplt_i) begin
                  res_d   = res_i;
                  ok_d    = 1'b1;
                  state_d = STORE;
               end else if (tmo_q == '0) begin
                  terr_d  = 1'b1;
                  ok_d    = 1'b0;
                  state_d = STORE;
               end else begin
                  tmo_d = tmo_q - TW'(1);
               end
            end
            STORE: begin
               if (ok_q) begin
                  pot_d[slot_q]   = store_val;
                  valid_d[slot_q] = 1'b1;
               end
               if (slot_q == LAST_SLOT) begin
                  slot_d  = '0;
                  gap_d   = GAP_RELOAD;
                  state_d = IDLE;
               end else begin
                  slot_d  = slot_q + 3'd1;
                  state_d = START;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (state_d == START) chnl_d = chnl_of(slot_d);
   end

   assign strt_cnv_o    = (state_q == START);
   assign sweep_done_o  = (state_q == STORE) && (slot_q == LAST_SLOT);
   assign chnl_o        = chnl_q;
   assign all_valid_o   = &valid_q;
   assign timeout_err_o = terr_q;
   assign lp_gain_o     = pot_q[0];
   assign b1_gain_o     = pot_q[1];
   assign b2_gain_o     = pot_q[2];
   assign b3_gain_o     = pot_q[3];
   assign hp_gain_o     = pot_q[4];
   assign volume_o      = pot_q[5];

endmodule
`default_nettype wire

// File: tb/tb_slide_pot_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_slide_pot_sequencer: directed bench with a delayed-reply A2D model.
// Revision 1.0
//------------------------------------------------------------------------------
module tb_slide_pot_sequencer;

   localparam int GAP   = 8;
   localparam int TMO   = 64;
   localparam int DLY   = 40;
`ifdef POT_SMOOTH_EN
   localparam logic [11:0] LP_SECOND = 12'd3000;
`else
   localparam logic [11:0] LP_SECOND = 12'd0;
`endif

   logic        clk, rst_n, restart_i, strt_cnv_o, cnv_cmplt_i;
   logic [2:0]  chnl_o;
   logic [11:0] res_i;
   logic [11:0] lp_gain_o, b1_gain_o, b2_gain_o, b3_gain_o, hp_gain_o, volume_o;
   logic        sweep_done_o, all_valid_o, timeout_err_o;

   int          n_checks = 0;
   int          n_errors = 0;
   int          sweep_pulses = 0;
   logic [7:0]  mute = 8'h00;
   logic        lp_ovr_en = 1'b0;
   logic [11:0] lp_ovr_val = 12'd0;
   int          stray_req = 0;

   slide_pot_sequencer #(.SWEEP_GAP(GAP), .TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .restart_i    (restart_i),
      .strt_cnv_o   (strt_cnv_o),
      .chnl_o       (chnl_o),
      .cnv_cmplt_i  (cnv_cmplt_i),
      .res_i        (res_i),
      .lp_gain_o    (lp_gain_o),
      .b1_gain_o    (b1_gain_o),
      .b2_gain_o    (b2_gain_o),
      .b3_gain_o    (b3_gain_o),
      .hp_gain_o    (hp_gain_o),
      .volume_o     (volume_o),
      .sweep_done_o (sweep_done_o),
      .all_valid_o  (all_valid_o),
      .timeout_err_o(timeout_err_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         if (sweep_done_o) sweep_pulses++;
      end
   end

   function automatic logic [11:0] reply_val(input logic [2:0] ch);
      if (ch == 3'd1 && lp_ovr_en) return lp_ovr_val;
      return 12'({9'h0, ch} * 12'd100);
   endfunction

   // A2D model: answers a strt_cnv DLY cycles later unless its channel is muted.
   initial begin
      logic       pending;
      int         pend_cnt;
      logic [2:0] pend_ch;
      int         stray_done;
      pending = 1'b0; pend_cnt = 0; pend_ch = 3'd0; stray_done = 0;
      cnv_cmplt_i = 1'b0;
      res_i = 12'd0;
      forever begin
         @(negedge clk);
         cnv_cmplt_i = 1'b0;
         if (!rst_n) begin
            pending = 1'b0;
         end else begin
            if (stray_req != stray_done) begin
               stray_done  = stray_req;
               cnv_cmplt_i = 1'b1;
               res_i       = 12'hABC;
            end
            if (pending) begin
               if (pend_cnt <= 1) begin
                  cnv_cmplt_i = 1'b1;
                  res_i       = reply_val(pend_ch);
                  pending     = 1'b0;
               end else begin
                  pend_cnt--;
               end
            end
            if (strt_cnv_o && !mute[chnl_o]) begin
               pending  = 1'b1;
               pend_cnt = DLY;
               pend_ch  = chnl_o;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Counts negedges until the selected output (0: strt_cnv, 1: sweep_done) is seen.
   task automatic wait_out(input bit sel_done, input int max, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < max && !ok) begin
         @(negedge clk);
         n++;
         if (sel_done ? sweep_done_o : strt_cnv_o) ok = 1'b1;
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (cycles) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      int n; bit ok;
      rst_n = 1'b0;
      restart_i = 1'b0;
      repeat (20) @(negedge clk);
      n_checks++;
      if ({strt_cnv_o, chnl_o, sweep_done_o, all_valid_o, timeout_err_o} !== 7'd0) begin
         n_errors++;
         $display("FAIL reset_ctrl got %b exp 0", {strt_cnv_o, chnl_o, sweep_done_o, all_valid_o, timeout_err_o});
      end
      n_checks++;
      if ({lp_gain_o, b1_gain_o, b2_gain_o, b3_gain_o, hp_gain_o, volume_o} !== 72'd0) begin
         n_errors++;
         $display("FAIL reset_gains got %h exp 0", {lp_gain_o, b1_gain_o, b2_gain_o, b3_gain_o, hp_gain_o, volume_o});
      end
      rst_n = 1'b1;
      wait_out(1'b0, 20, n, ok);
      n_checks++;
      if (!ok || n != 2) begin
         n_errors++;
         $display("FAIL reset_first_strt got %0d exp 2 (seen=%0d)", n, ok);
      end
      n_checks++;
      if (chnl_o !== 3'd1) begin
         n_errors++;
         $display("FAIL reset_first_chnl got %0d exp 1", chnl_o);
      end
   endtask

   task automatic test_sweep();
      int n; bit ok; int p0;
      int exp_ch [5] = '{0, 4, 2, 3, 7};
      p0 = sweep_pulses;
      for (int i = 0; i < 5; i++) begin
         wait_out(1'b0, 200, n, ok);
         n_checks++;
         if (!ok || n != DLY + 2) begin
            n_errors++;
            $display("FAIL sweep_interval[%0d] got %0d exp %0d", i, n, DLY + 2);
         end
         n_checks++;
         if (chnl_o !== 3'(exp_ch[i])) begin
            n_errors++;
            $display("FAIL sweep_chnl[%0d] got %0d exp %0d", i, chnl_o, exp_ch[i]);
         end
      end
      wait_out(1'b1, 200, n, ok);
      n_checks++;
      if (!ok || n != DLY + 1) begin
         n_errors++;
         $display("FAIL sweep_done_time got %0d exp %0d", n, DLY + 1);
      end
      n_checks++;
      if (all_valid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL sweep_valid_early got %b exp 0", all_valid_o);
      end
      @(negedge clk);
      n_checks++;
      if ({lp_gain_o, b1_gain_o, b2_gain_o, b3_gain_o, hp_gain_o, volume_o} !==
          {12'd100, 12'd0, 12'd400, 12'd200, 12'd300, 12'd700}) begin
         n_errors++;
         $display("FAIL sweep_gains got %0d %0d %0d %0d %0d %0d exp 100 0 400 200 300 700",
                  lp_gain_o, b1_gain_o, b2_gain_o, b3_gain_o, hp_gain_o, volume_o);
      end
      n_checks++;
      if ({all_valid_o, timeout_err_o, sweep_done_o} !== 3'b100) begin
         n_errors++;
         $display("FAIL sweep_flags got %b exp 100", {all_valid_o, timeout_err_o, sweep_done_o});
      end
      wait_out(1'b0, 100, n, ok);
      n_checks++;
      if (!ok || n != GAP || chnl_o !== 3'd1) begin
         n_errors++;
         $display("FAIL sweep_gap got %0d chnl %0d exp %0d chnl 1", n + 1, chnl_o, GAP + 1);
      end
      n_checks++;
      if (sweep_pulses - p0 != 1) begin
         n_errors++;
         $display("FAIL sweep_done_count got %0d exp 1", sweep_pulses - p0);
      end
   endtask

   task automatic test_timeout();
      int n; bit ok;
      mute = 8'h10;
      do_reset(3);
      for (int i = 0; i < 3; i++) wait_out(1'b0, 200, n, ok);
      n_checks++;
      if (!ok || chnl_o !== 3'd4 || timeout_err_o !== 1'b0) begin
         n_errors++;
         $display("FAIL tmo_pre got chnl %0d err %b exp chnl 4 err 0", chnl_o, timeout_err_o);
      end
      wait_out(1'b0, 200, n, ok);
      n_checks++;
      if (!ok || n != TMO + 2 || chnl_o !== 3'd2) begin
         n_errors++;
         $display("FAIL tmo_next_strt got %0d chnl %0d exp %0d chnl 2", n, chnl_o, TMO + 2);
      end
      n_checks++;
      if (timeout_err_o !== 1'b1 || b2_gain_o !== 12'd0) begin
         n_errors++;
         $display("FAIL tmo_state got err %b b2 %0d exp err 1 b2 0", timeout_err_o, b2_gain_o);
      end
      wait_out(1'b1, 300, n, ok);
      @(negedge clk);
      n_checks++;
      if (!ok || all_valid_o !== 1'b0 || hp_gain_o !== 12'd300 || timeout_err_o !== 1'b1) begin
         n_errors++;
         $display("FAIL tmo_end got valid %b hp %0d err %b exp valid 0 hp 300 err 1",
                  all_valid_o, hp_gain_o, timeout_err_o);
      end
      mute = 8'h00;
   endtask

   task automatic test_restart();
      int n; bit ok;
      do_reset(3);
      for (int i = 0; i < 4; i++) wait_out(1'b0, 200, n, ok);
      n_checks++;
      if (!ok || chnl_o !== 3'd2) begin
         n_errors++;
         $display("FAIL rst_slot3 got chnl %0d exp 2", chnl_o);
      end
      repeat (10) @(negedge clk);
      restart_i = 1'b1;
      @(negedge clk);
      restart_i = 1'b0;
      n_checks++;
      if ({strt_cnv_o, chnl_o} !== 4'b1_001 || b3_gain_o !== 12'd0) begin
         n_errors++;
         $display("FAIL restart_strt got strt %b chnl %0d b3 %0d exp strt 1 chnl 1 b3 0",
                  strt_cnv_o, chnl_o, b3_gain_o);
      end
      wait_out(1'b1, 400, n, ok);
      stray_req++;
      wait_out(1'b0, 100, n, ok);
      n_checks++;
      if (!ok || n != GAP + 1) begin
         n_errors++;
         $display("FAIL stray_gap got %0d exp %0d", n, GAP + 1);
      end
      n_checks++;
      if ({lp_gain_o, b3_gain_o, volume_o, all_valid_o} !== {12'd100, 12'd200, 12'd700, 1'b1}) begin
         n_errors++;
         $display("FAIL stray_gains got lp %0d b3 %0d vol %0d valid %b exp 100 200 700 1",
                  lp_gain_o, b3_gain_o, volume_o, all_valid_o);
      end
   endtask

   task automatic test_reset_mid_wait();
      int n; bit ok;
      do_reset(3);
      for (int i = 0; i < 3; i++) wait_out(1'b0, 200, n, ok);
      n_checks++;
      if (!ok || chnl_o !== 3'd4 || lp_gain_o !== 12'd100) begin
         n_errors++;
         $display("FAIL midwait_pre got chnl %0d lp %0d exp chnl 4 lp 100", chnl_o, lp_gain_o);
      end
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({strt_cnv_o, chnl_o, lp_gain_o, b1_gain_o} !== 28'd0) begin
         n_errors++;
         $display("FAIL midwait_clear got strt %b chnl %0d lp %0d exp 0 0 0", strt_cnv_o, chnl_o, lp_gain_o);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (strt_cnv_o !== 1'b0) begin
         n_errors++;
         $display("FAIL midwait_hold got strt %b exp 0", strt_cnv_o);
      end
      rst_n = 1'b1;
      wait_out(1'b0, 20, n, ok);
      n_checks++;
      if (!ok || n != 2 || chnl_o !== 3'd1) begin
         n_errors++;
         $display("FAIL midwait_restart got %0d chnl %0d exp 2 chnl 1", n, chnl_o);
      end
   endtask

   task automatic test_smooth();
      int n; bit ok;
      lp_ovr_en  = 1'b1;
      lp_ovr_val = 12'd4000;
      do_reset(3);
      wait_out(1'b1, 400, n, ok);
      @(negedge clk);
      n_checks++;
      if (!ok || lp_gain_o !== 12'd4000) begin
         n_errors++;
         $display("FAIL smooth_first got %0d exp 4000", lp_gain_o);
      end
      lp_ovr_val = 12'd0;
      wait_out(1'b1, 400, n, ok);
      @(negedge clk);
      n_checks++;
      if (!ok || lp_gain_o !== LP_SECOND) begin
         n_errors++;
         $display("FAIL smooth_second got %0d exp %0d", lp_gain_o, LP_SECOND);
      end
      lp_ovr_en = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      restart_i = 1'b0;
      test_reset();
      test_sweep();
      test_timeout();
      test_restart();
      test_reset_mid_wait();
      test_smooth();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
